mlp_stream_loader: RTL
======================

Name: mlp_stream_loader

Overview:
- Write-side feeder for the mlp inference block. It accepts a serial word stream on a valid/ready interface.
- It deserialises the stream into the parallel weight, bias and input arrays that mlp consumes.
- A parameter block (W1, B1, W2, B2) is loaded once. Input frames of NIn words then follow repeatedly.
- Each completed frame is presented atomically with a one-cycle strobe.

Parameters:
- NBits, 16, word width of every weight, bias and data element
- NIn, 6, input vector length (layer-1 fan-in)
- NHid, 16, hidden layer width
- NOut, 3, output layer width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- s_valid_i  in  1  stream word valid
- s_ready_o  out  1  stream word ready
- s_data_i  in  NBits  stream word
- s_last_i  in  1  marks final word of a parameter block or input frame
- reload_i  in  1  synchronous pulse; restart parameter load
- w1_o  out  NIn x NHid x NBits  layer-1 weights, indexed [i][j]
- b1_o  out  NHid x NBits  layer-1 biases
- w2_o  out  NHid x NOut x NBits  layer-2 weights, indexed [j][k]
- b2_o  out  NOut x NBits  layer-2 biases
- din_o  out  NIn x NBits  current input frame
- params_valid_o  out  1  all parameters loaded and consistent
- din_valid_o  out  1  one-cycle strobe: new frame on din_o
- err_o  out  1  sticky framing error

Behaviour:
- Reset (async assert, sync release):
  - All arrays are 0; params_valid_o, din_valid_o and err_o are 0; s_ready_o is 0.
  - State is LOAD with count 0. s_ready_o rises on the first clock after release.
- A beat is accepted when s_valid_i and s_ready_o are both high at the rising edge. s_ready_o is registered; it is 1 in LOAD and FRAME and 0 only in the first cycle after reset release.
- Parameter order, PTotal = NIn*NHid + NHid + NHid*NOut + NOut (163 by default):
  - W1 row-major: w1[i][j] at index i*NHid+j.
  - Then B1, then W2 row-major (w2[j][k]), then B2.
- LOAD:
  - Each accepted beat writes its target element directly at the edge and increments count.
  - The beat at count = PTotal-1 moves to FRAME, resets count to 0 and sets params_valid_o the next cycle.
- FRAME:
  - Accepted beats write a staging buffer stage[count].
  - The beat at count = NIn-1 copies the staging buffer, including that final word, into din_o. din_valid_o is high for exactly the following cycle. count wraps to 0.
  - din_o changes only at frame completion.
- Back-to-back frames are allowed with no idle cycle. din_valid_o may be high on consecutive strobes spaced NIn cycles apart at full rate.
- s_last_i rules:
  - Early last (asserted before the final beat): the beat is discarded, count resets to 0, state is unchanged, err_o is set.
  - Missing last on the final beat: the block completes normally and err_o is set.
- reload_i:
  - Next state is LOAD with count 0, and params_valid_o clears the next cycle.
  - A beat accepted in the same cycle as reload_i is discarded.
  - Array contents are retained until overwritten.
  - din_valid_o is not asserted after reload until a full frame completes.
  - err_o is cleared only by rst_i.
- Reset mid-block: all state returns to reset values immediately, and partial data is lost.
- Counter width: clog2(PTotal). No arithmetic is performed on data words.

Decomposition:
- Shared package mlp_pkg holds:
  - NBits, NIn, NHid, NOut, PTotal;
  - word_t;
  - the loader state enum {LOAD, FRAME};
  - the region offset constants W1Off, B1Off, W2Off, B2Off.
- One sub-module, mlp_param_decode (combinational). It maps the linear count to a region select and row/column indices, keeping the index math out of the FSM.

Test Plan:
- Reset, then stream 163 words with value = index+1 and last on word 163:
  - w1_o[0][0]=1, w1_o[5][15]=96, b1_o[0]=97, w2_o[15][2]=160, b2_o[2]=163;
  - params_valid_o rises the cycle after the final beat; err_o=0.
- After the load, send frame 0x10..0x15 with last on the 6th word:
  - din_o={0x10..0x15}; din_valid_o high exactly one cycle;
  - din_o unchanged during the next frame's first 5 beats.
- Two frames back-to-back with s_valid_i held high for 12 cycles: two strobes 6 cycles apart, second din_o correct.
- s_last_i on the 3rd word of a frame:
  - err_o=1, no strobe;
  - the following clean 6-word frame is delivered correctly.
- reload_i asserted mid-frame together with a valid beat:
  - params_valid_o=0 next cycle and that beat is dropped;
  - a new 163-word load with value = 0xA000+index gives w1_o[0][0]=0xA000 and restores params_valid_o.
- rst_i asserted at param word 50 then released:
  - all outputs are 0 and s_ready_o is 0 for one cycle;
  - a full reload then succeeds.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared configuration, types and parameter-block layout for the mlp stream loader.
package mlp_pkg;

  localparam int unsigned NBits  = 16;
  localparam int unsigned NIn    = 6;
  localparam int unsigned NHid   = 16;
  localparam int unsigned NOut   = 3;
  localparam int unsigned PTotal = NIn * NHid + NHid + NHid * NOut + NOut;

  // Linear offsets of each region inside the parameter block.
  localparam int unsigned W1Off = 0;
  localparam int unsigned B1Off = W1Off + NIn * NHid;
  localparam int unsigned W2Off = B1Off + NHid;
  localparam int unsigned B2Off = W2Off + NHid * NOut;

  localparam int unsigned CntW = $clog2(PTotal);
  localparam int unsigned IW   = $clog2(NIn);
  localparam int unsigned JW   = $clog2(NHid);
  localparam int unsigned KW   = $clog2(NOut);

  typedef logic [NBits-1:0] word_t;
  typedef logic [CntW-1:0]  cnt_t;

  typedef enum logic {LOAD, FRAME} loader_state_e;
  typedef enum logic [1:0] {RegW1, RegB1, RegW2, RegB2} region_e;

endpackage

// File: rtl/mlp_param_decode.sv
// Maps a linear parameter-block position to its target region and array indices.
module mlp_param_decode
  import mlp_pkg::*;
(
  input  cnt_t            count,
  output region_e         region,
  output logic [IW-1:0]   i_idx,
  output logic [JW-1:0]   j_idx,
  output logic [KW-1:0]   k_idx
);

  cnt_t off;

  always_comb begin
    region = RegW1;
    off    = count - cnt_t'(W1Off);
    i_idx  = '0;
    j_idx  = '0;
    k_idx  = '0;
    if (count >= cnt_t'(B2Off)) begin
      region = RegB2;
      off    = count - cnt_t'(B2Off);
      k_idx  = KW'(off);
    end else if (count >= cnt_t'(W2Off)) begin
      region = RegW2;
      off    = count - cnt_t'(W2Off);
      j_idx  = JW'(off / cnt_t'(NOut));
      k_idx  = KW'(off % cnt_t'(NOut));
    end else if (count >= cnt_t'(B1Off)) begin
      region = RegB1;
      off    = count - cnt_t'(B1Off);
      j_idx  = JW'(off);
    end else begin
      i_idx  = IW'(off / cnt_t'(NHid));
      j_idx  = JW'(off % cnt_t'(NHid));
    end
  end

endmodule

// File: rtl/mlp_stream_loader.sv
// Deserialises a valid/ready word stream into mlp parameter arrays and input frames.
module mlp_stream_loader
  import mlp_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  word_t                       s_data_i,
  input  logic                        s_last_i,
  input  logic                        reload_i,
  output word_t [NIn-1:0][NHid-1:0]   w1_o,
  output word_t [NHid-1:0]            b1_o,
  output word_t [NHid-1:0][NOut-1:0]  w2_o,
  output word_t [NOut-1:0]            b2_o,
  output word_t [NIn-1:0]             din_o,
  output logic                        params_valid_o,
  output logic                        din_valid_o,
  output logic                        err_o
);

  loader_state_e state_q, state_d;
  cnt_t          count_q, count_d;
  logic          ready_q;
  logic          pv_q, pv_d;
  logic          dv_q, dv_d;
  logic          err_q, err_d;
  logic          wr_param, wr_stage, frame_done;
  logic          accept, final_beat;

  word_t [NIn-1:0][NHid-1:0]  w1_q;
  word_t [NHid-1:0]           b1_q;
  word_t [NHid-1:0][NOut-1:0] w2_q;
  word_t [NOut-1:0]           b2_q;
  word_t [NIn-1:0]            din_q;
  word_t [NIn-1:0]            stage_q;

  region_e         region;
  logic [IW-1:0]   i_idx;
  logic [JW-1:0]   j_idx;
  logic [KW-1:0]   k_idx;

  mlp_param_decode u_decode (
    .count  (count_q),
    .region (region),
    .i_idx  (i_idx),
    .j_idx  (j_idx),
    .k_idx  (k_idx)
  );

  assign accept     = s_valid_i & ready_q;
  assign final_beat = (state_q == LOAD) ? (count_q == cnt_t'(PTotal - 1))
                                        : (count_q == cnt_t'(NIn - 1));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pv_d       = pv_q;
    dv_d       = 1'b0;
    err_d      = err_q;
    wr_param   = 1'b0;
    wr_stage   = 1'b0;
    frame_done = 1'b0;
    if (reload_i) begin
      // Any beat in the reload cycle is dropped.
      state_d = LOAD;
      count_d = '0;
      pv_d    = 1'b0;
    end else if (accept) begin
      if (s_last_i && !final_beat) begin
        count_d = '0;
        err_d   = 1'b1;
      end else begin
        wr_param = (state_q == LOAD);
        wr_stage = (state_q == FRAME);
        if (final_beat) begin
          count_d = '0;
          if (!s_last_i) err_d = 1'b1;
          if (state_q == LOAD) begin
            state_d = FRAME;
            pv_d    = 1'b1;
          end else begin
            frame_done = 1'b1;
            dv_d       = 1'b1;
          end
        end else begin
          count_d = count_q + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LOAD;
      count_q <= '0;
      ready_q <= 1'b0;
      pv_q    <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ready_q <= 1'b1;
      pv_q    <= pv_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w1_q    <= '0;
      b1_q    <= '0;
      w2_q    <= '0;
      b2_q    <= '0;
      din_q   <= '0;
      stage_q <= '0;
    end else begin
      if (wr_param) begin
        unique case (region)
          RegW1: w1_q[i_idx][j_idx] <= s_data_i;
          RegB1: b1_q[j_idx]        <= s_data_i;
          RegW2: w2_q[j_idx][k_idx] <= s_data_i;
          RegB2: b2_q[k_idx]        <= s_data_i;
        endcase
      end
      if (wr_stage) stage_q[count_q[IW-1:0]] <= s_data_i;
      // The closing word bypasses staging so the whole frame lands in one edge.
      if (frame_done) begin
        din_q          <= stage_q;
        din_q[NIn-1]   <= s_data_i;
      end
    end
  end

  assign s_ready_o      = ready_q;
  assign params_valid_o = pv_q;
  assign din_valid_o    = dv_q;
  assign err_o          = err_q;
  assign w1_o           = w1_q;
  assign b1_o           = b1_q;
  assign w2_o           = w2_q;
  assign b2_o           = b2_q;
  assign din_o          = din_q;

endmodule
